// File: rtl/instr_loader.sv
// instr_loader: packs the UART RX byte stream (big-endian) into 32-bit words and writes them to IF instruction memory from address 0.
// Latency: the write strobe appears one cycle after the edge that accepts a word's 4th byte; HALT/overflow status appears with that strobe.
// Backpressure: none; one byte per cycle is absorbed. Optional LOADER_CHECKSUM_EN adds a trailing XOR checksum byte after HALT.
module instr_loader #(
  parameter int unsigned          BITS_SIZE  = 32,
  parameter int unsigned          SIZE_TOTAL = 256,
  parameter logic [BITS_SIZE-1:0] HALT_WORD  = 32'hFFFFFFFF
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic                 i_rx_done,
  input  logic [7:0]           i_rx_data,
  output logic [BITS_SIZE-1:0] o_instruction_address,
  output logic [BITS_SIZE-1:0] o_instruction,
  output logic                 o_flag_write_intruc,
  output logic                 o_loading,
  output logic                 o_load_done,
  output logic                 o_overflow,
  output logic                 o_load_error
);

  // Byte address of the last word slot; writing a non-HALT word here ends the load.
  localparam logic [BITS_SIZE-1:0] LAST_ADDR  = BITS_SIZE'(SIZE_TOTAL - 4);
  localparam logic [BITS_SIZE-1:0] WORD_BYTES = BITS_SIZE'(4);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, RECV, DONE, CHECK} state_t;
`else
  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;
`endif

  state_t                 state;
  logic [1:0]             byte_cnt;
  logic [BITS_SIZE-1:0]   addr_cnt;
  // Only the first three bytes need storing; the fourth comes straight from i_rx_data.
  logic [BITS_SIZE-9:0]   asm_word;
  logic [BITS_SIZE-1:0]   word_next;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]             csum;
`endif

  // Word formed by the bytes held so far plus the byte arriving this cycle.
  assign word_next = {asm_word, i_rx_data};

`ifndef LOADER_CHECKSUM_EN
  assign o_load_error = 1'b0;
`endif

  // Loader FSM: state, byte/address counters, assembly register and all registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state                 <= IDLE;
      byte_cnt              <= 2'd0;
      addr_cnt              <= '0;
      asm_word              <= '0;
      o_instruction_address <= '0;
      o_instruction         <= '0;
      o_flag_write_intruc   <= 1'b0;
      o_loading             <= 1'b0;
      o_load_done           <= 1'b0;
      o_overflow            <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum                  <= 8'h00;
      o_load_error          <= 1'b0;
`endif
    end else begin
      o_flag_write_intruc <= 1'b0;
      if (i_start) begin
        // Start (or restart mid-load): drop any partial word and begin again at address 0.
        state       <= RECV;
        o_loading   <= 1'b1;
        byte_cnt    <= 2'd0;
        addr_cnt    <= '0;
        asm_word    <= '0;
        o_load_done <= 1'b0;
        o_overflow  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
        csum         <= 8'h00;
        o_load_error <= 1'b0;
`endif
      end else begin
        case (state)
          RECV: begin
            if (i_rx_done) begin
              byte_cnt <= byte_cnt + 2'd1;
              asm_word <= word_next[BITS_SIZE-9:0];
`ifdef LOADER_CHECKSUM_EN
              csum     <= csum ^ i_rx_data;
`endif
              if (byte_cnt == 2'd3) begin
                o_instruction         <= word_next;
                o_instruction_address <= addr_cnt;
                o_flag_write_intruc   <= 1'b1;
                addr_cnt              <= addr_cnt + WORD_BYTES;
                if (word_next == HALT_WORD) begin
                  // HALT is still written; status flips in the same cycle as its strobe.
                  o_loading <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                  state       <= CHECK;
`else
                  state       <= DONE;
                  o_load_done <= 1'b1;
`endif
                end else if (addr_cnt == LAST_ADDR) begin
                  // Memory full without HALT: stop here so the address never wraps.
                  state       <= DONE;
                  o_loading   <= 1'b0;
                  o_load_done <= 1'b1;
                  o_overflow  <= 1'b1;
                end
              end
            end
          end
`ifdef LOADER_CHECKSUM_EN
          CHECK: begin
            if (i_rx_done) begin
              state        <= DONE;
              o_load_done  <= 1'b1;
              o_load_error <= (i_rx_data != csum);
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: randomized byte streams checked cycle-by-cycle against a queue-based program-load model.
// Latency: every output is compared 2 time units after each rising edge.
// Backpressure: none; bytes are offered at random gaps including back-to-back.
module tb_instr_loader;

  localparam int          SIZE_TOTAL = 256;
  localparam logic [31:0] HALT       = 32'hFFFFFFFF;

  logic        i_clk;
  logic        i_reset;
  logic        i_start;
  logic        i_rx_done;
  logic [7:0]  i_rx_data;
  logic [31:0] o_instruction_address;
  logic [31:0] o_instruction;
  logic        o_flag_write_intruc;
  logic        o_loading;
  logic        o_load_done;
  logic        o_overflow;
  logic        o_load_error;

  instr_loader #(
    .BITS_SIZE (32),
    .SIZE_TOTAL(SIZE_TOTAL),
    .HALT_WORD (HALT)
  ) dut (
    .i_clk                (i_clk),
    .i_reset              (i_reset),
    .i_start              (i_start),
    .i_rx_done            (i_rx_done),
    .i_rx_data            (i_rx_data),
    .o_instruction_address(o_instruction_address),
    .o_instruction        (o_instruction),
    .o_flag_write_intruc  (o_flag_write_intruc),
    .o_loading            (o_loading),
    .o_load_done          (o_load_done),
    .o_overflow           (o_overflow),
    .o_load_error         (o_load_error)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a load session holding the bytes of the word in progress.
  logic [7:0]  m_cur[$];
  int          m_addr = 0;
  bit          m_loading = 0, m_check = 0, m_done = 0, m_ovf = 0, m_err = 0, m_strobe = 0;
  logic [31:0] m_last_addr = 0, m_last_data = 0;
  logic [7:0]  m_csum = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic model_step(input bit rst, input bit st, input bit v, input logic [7:0] b);
    logic [31:0] w;
    m_strobe = 0;
    if (rst) begin
      m_loading = 0; m_check = 0; m_done = 0; m_ovf = 0; m_err = 0;
      m_addr = 0; m_cur.delete(); m_last_addr = 0; m_last_data = 0; m_csum = 0;
    end else if (st) begin
      m_loading = 1; m_check = 0; m_done = 0; m_ovf = 0; m_err = 0;
      m_addr = 0; m_cur.delete(); m_csum = 0;
    end else if (v && m_loading) begin
      m_cur.push_back(b);
      m_csum = m_csum ^ b;
      if (m_cur.size() == 4) begin
        w = {m_cur[0], m_cur[1], m_cur[2], m_cur[3]};
        m_cur.delete();
        m_strobe    = 1;
        m_last_addr = 32'(m_addr);
        m_last_data = w;
        if (w == HALT) begin
          m_loading = 0;
`ifdef LOADER_CHECKSUM_EN
          m_check = 1;
`else
          m_done = 1;
`endif
        end else if (m_addr == SIZE_TOTAL - 4) begin
          m_loading = 0; m_done = 1; m_ovf = 1;
        end
        m_addr += 4;
      end
    end else if (v && m_check) begin
      m_check = 0;
      m_done  = 1;
      m_err   = (b != m_csum);
    end
  endtask

  // One clock: apply inputs, advance the model, then compare every output after the edge.
  task automatic cycle(input bit rst, input bit st, input bit v, input logic [7:0] b);
    i_reset = rst; i_start = st; i_rx_done = v; i_rx_data = b;
    model_step(rst, st, v, b);
    @(posedge i_clk);
    #2;
    check("strobe",  32'(o_flag_write_intruc), 32'(m_strobe));
    check("loading", 32'(o_loading),           32'(m_loading));
    check("done",    32'(o_load_done),         32'(m_done));
    check("ovf",     32'(o_overflow),          32'(m_ovf));
    check("err",     32'(o_load_error),        32'(m_err));
    check("addr",    o_instruction_address,    m_last_addr);
    check("instr",   o_instruction,            m_last_data);
    i_reset = 0; i_start = 0; i_rx_done = 0;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic do_start();
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    cycle(1'b0, 1'b0, 1'b1, b);
    if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) idle();
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8], max_gap);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom();
    if (w == HALT) w = 32'h0;
    return w;
  endfunction

  task automatic send_checksum(input bit good);
`ifdef LOADER_CHECKSUM_EN
    send_byte(good ? m_csum : (m_csum ^ 8'h5A), 0);
`else
    if (good) idle();
`endif
  endtask

  task automatic random_load(input int nwords, input int max_gap);
    do_start();
    for (int k = 0; k < nwords - 1; k++) send_word(rand_word(), max_gap);
    send_word(HALT, max_gap);
    send_checksum($urandom_range(1, 0) == 1);
    repeat (2) idle();
  endtask

  initial begin
    i_reset = 1; i_start = 0; i_rx_done = 0; i_rx_data = 0;

    // Reset state
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    idle();

    // Reset mid-word, then a fresh word lands at address 0
    do_start();
    send_byte(8'h20, 0);
    send_byte(8'h01, 0);
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    idle();
    do_start();
    send_word(32'h12345678, 1);
    idle();

    // Simple load with HALT
    do_start();
    send_word(32'h20080005, 2);
    send_word(HALT, 2);
    send_checksum(1'b1);
    repeat (3) idle();
    // Bytes in DONE are ignored
    send_word(32'hA5A5A5A5, 0);

    // Back-to-back: 3 words, the last one HALT, no gaps
    do_start();
    send_word(32'hDEADBEEF, 0);
    send_word(32'h01234567, 0);
    send_word(HALT, 0);
    send_checksum(1'b1);
    idle();

    // Overflow: 64 zero words, then extra bytes must not strobe
    do_start();
    for (int k = 0; k < SIZE_TOTAL / 4; k++) send_word(32'h0, 0);
    send_word(32'h11223344, 0);
    repeat (2) idle();

    // Last slot holding HALT: no overflow
    do_start();
    for (int k = 0; k < SIZE_TOTAL / 4 - 1; k++) send_word(rand_word(), 0);
    send_word(HALT, 0);
    send_checksum(1'b1);
    idle();

    // Restart from DONE, and restart mid-word in RECV
    do_start();
    send_word(32'hCAFEF00D, 1);
    send_byte(8'h99, 0);
    do_start();
    send_word(32'h0BADC0DE, 0);
    send_word(HALT, 0);
    send_checksum(1'b0);
    idle();

`ifdef LOADER_CHECKSUM_EN
    // Checksum: 01^02^03^04^FF^FF^FF^FF = 04
    do_start();
    send_word(32'h01020304, 0);
    send_word(HALT, 0);
    send_byte(8'h04, 0);
    idle();
    do_start();
    send_word(32'h01020304, 0);
    send_word(HALT, 0);
    send_byte(8'h05, 0);
    idle();
`endif

    // Randomized sessions
    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(3, 0))
        0: random_load(int'($urandom_range(8, 1)), int'($urandom_range(2, 0)));
        1: begin
          do_start();
          repeat ($urandom_range(3, 1)) send_byte(8'($urandom), 1);
          random_load(int'($urandom_range(5, 1)), 1);
        end
        2: begin
          random_load(int'($urandom_range(4, 1)), 0);
          repeat (5) send_byte(8'($urandom), 0);
        end
        default: begin
          do_start();
          repeat ($urandom_range(9, 1)) send_byte(8'($urandom), 1);
          cycle(1'b1, 1'b0, 1'b0, 8'h00);
          repeat (3) send_byte(8'($urandom), 0);
        end
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Upstream feeder of the IF stage instruction memory.
- Assembles a serial byte stream (UART RX output) into 32-bit MIPS instructions and drives the IF write port: instruction address, instruction word and write flag.
- Writes start at address 0. Loading ends on the HALT word or when memory is full.
- Holds the processor out of execution while loading.

Parameters:
- BITS_SIZE, 32, width of address and instruction words.
- SIZE_TOTAL, 256, instruction memory size in bytes (64 words).
- HALT_WORD, 32'hFFFFFFFF, end-of-program marker.

Ports:
- i_clk  input  1  system clock; all logic on rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_start  input  1  pulse: begin a new load from address 0.
- i_rx_done  input  1  one-cycle strobe: i_rx_data valid.
- i_rx_data  input  8  received byte.
- o_instruction_address  output  BITS_SIZE  byte address of the word being written.
- o_instruction  output  BITS_SIZE  assembled instruction.
- o_flag_write_intruc  output  1  one-cycle write strobe to instruction memory.
- o_loading  output  1  high while in RECV state.
- o_load_done  output  1  level: program loaded; cleared by i_start or reset.
- o_overflow  output  1  level: memory filled without HALT.
- o_load_error  output  1  checksum mismatch; only driven with the macro, else tied 0.

Behaviour:
- Interface (already decided): one clock, i_clk. Reset i_reset is synchronous and active-high.
- Reset (any state, including mid-word):
  - state=IDLE.
  - Byte counter=0, address counter=0, assembly register=0.
  - All outputs 0.
- FSM states: IDLE, RECV, DONE (plus CHECK with the macro).
  - IDLE --i_start--> RECV.
  - RECV --HALT written or overflow--> DONE.
  - DONE --i_start--> RECV.
  - i_start in RECV: restart. Counters cleared, partial word discarded, stay in RECV.
- Byte capture:
  - Accepted only in RECV with i_rx_done=1. Bytes in IDLE/DONE are ignored.
  - Big-endian: byte 0 goes to bits[31:24], byte 3 to bits[7:0].
  - 2-bit byte counter wraps 3→0.
- Word write:
  - On the edge accepting byte 3, output registers load the full word and current address.
  - o_flag_write_intruc=1 for exactly the following cycle.
  - Address counter then increments by 4.
  - Back-to-back bytes (i_rx_done every cycle) are supported. Assembly and output registers are independent, so no byte is lost.
- HALT:
  - A word equal to HALT_WORD is still written to memory.
  - In the same cycle as its write strobe, state→DONE and o_load_done=1.
- Overflow:
  - When the word at address SIZE_TOTAL-4 is written and is not HALT: state→DONE, o_load_done=1, o_overflow=1.
  - The address never wraps to 0 within a load.
  - If the last-slot word is HALT, o_overflow stays 0.
- o_loading = (state==RECV).
- o_instruction and o_instruction_address hold their last written values until the next write.
- Widths: address counter is BITS_SIZE wide. Comparisons against SIZE_TOTAL-4 are unsigned.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- With macro:
  - Running XOR of all accepted bytes, HALT bytes included.
  - After HALT, the FSM enters CHECK instead of DONE and waits for one more byte.
  - On that byte it enters DONE and sets o_load_done=1.
  - o_load_error=1 if the byte differs from the running XOR.
  - Overflow bypasses CHECK: goes to DONE, o_load_error=0.
- Without macro: no CHECK state; o_load_error constant 0; DONE entered as above.

Test Plan:
- Reset mid-word: i_start, send 8'h20, 8'h01, then i_reset → next cycle all outputs 0. Send 4 bytes → write strobe at address 0.
- Simple load: i_start, bytes 20 08 00 05, FF FF FF FF →
  - Strobe 1: addr 0, data 32'h20080005.
  - Strobe 2: addr 4, data 32'hFFFFFFFF.
  - o_load_done=1 in the cycle of strobe 2; o_overflow=0.
- Back-to-back: i_rx_done every cycle for 12 bytes (3 words, last HALT) → 3 strobes exactly 4 cycles apart at addresses 0, 4, 8; no byte lost.
- Overflow: 64 non-HALT words 32'h00000000 → last strobe at addr 252, then o_overflow=1 and o_load_done=1. Bytes after this produce no strobe.
- Restart: in DONE, pulse i_start, send 4 bytes → strobe at addr 0; o_load_done cleared on i_start.
- With LOADER_CHECKSUM_EN: bytes 01 02 03 04 FF FF FF FF →
  - Checksum byte 8'h04: o_load_done=1, o_load_error=0.
  - Repeat with checksum byte 8'h05: o_load_error=1.
